gate_pipe_unit: RTL and testbench
=================================

# gate_pipe_unit

Parametrised pipelined bitwise logic unit: the next generation of our single-bit wire/reg gate pair. Takes two WIDTH-bit operands plus an opcode, presents the combinational result immediately (wire path), and delivers the same result through a STAGES-deep registered pipeline (reg path) with valid/ready flow control and a completed-result counter. It is the operand-logic building block for later datapath assignments and is checked against its own wire path in simulation.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- STAGES, 2, pipeline depth of the registered path (≥1)
- CNT_W, 16, width of the completed-result counter (≥1)

- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- y_comb  output  WIDTH  combinational result of current a, b, op (wire path)
- out_valid  output  1  registered result present
- out_ready  input  1  downstream accepts result
- y_reg  output  WIDTH  registered result (reg path)
- y_op  output  3  opcode that produced y_reg
- out_count  output  CNT_W  number of results accepted downstream

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored), 7 a AND NOT b. All bitwise across WIDTH; no carries, no width growth.
- y_comb: purely combinational from a, b, op; independent of clk, rst, in_valid, handshakes.
- Pipeline: STAGES register stages, each holding {valid, result, op}. Stage 0 captures the computed result of (a, b, op) and in_valid; stage k captures stage k-1; last stage drives out_valid, y_reg, y_op.
- Global advance: en = !out_valid || out_ready. When en=1 all stages shift one place; when en=0 all stages hold.
- in_ready = en (combinational). Input transfer occurs on in_valid && in_ready; a beat offered while in_ready=0 is not captured and must be held by the source.
- Bubbles are not collapsed: an empty stage shifts through like data.
- out_count increments by 1 on each cycle with out_valid && out_ready; wraps 2^CNT_W-1 -> 0 with no flag.
- Result is computed at capture: changing a/b/op after transfer does not alter the in-flight beat.
- y_reg and y_op hold their value while out_valid && !out_ready.

## Timing
- Reset (rst=1 at an edge): all stage valids 0, stage data/op 0, out_valid 0, y_reg 0, y_op 0, out_count 0. Takes effect at that edge; in-flight beats are discarded; an input offered in the rst cycle is discarded.
- First cycle after reset: out_valid 0 so in_ready 1.
- Latency: beat transferred at edge N appears with out_valid=1 after edge N+STAGES-1 (i.e. visible in cycle N+STAGES) when no stall.
- Throughput: one beat per cycle with out_ready held 1.
- Stall: out_ready=0 with out_valid=1 freezes all stages and drops in_ready same cycle; releasing out_ready restores in_ready same cycle (no dead cycle).
- Simultaneous output accept and input transfer in one cycle: both occur; pipeline shifts once.
- Counter increment and reset in the same cycle: reset wins (count 0).
- y_comb has zero-cycle latency; y_reg must equal y_comb sampled at transfer time.

## Test plan
- Reset: drive rst=1 two cycles mid-stream with 2 beats in flight -> out_valid 0, y_reg 0x00, y_op 0, out_count 0 after the edge; in-flight beats never appear.
- Opcode sweep (WIDTH=8, STAGES=2, out_ready=1): a=0xC3, b=0xA5, op 0..7 back to back -> y_comb same cycle and y_reg 2 cycles later = 0x81, 0xE7, 0x66, 0x7E, 0x18, 0x99, 0x3C, 0x42 with matching y_op.
- Backpressure: stream 4 beats, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready 0 during hold, y_reg stable, no beat lost or duplicated, order preserved.
- Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by STAGES cycles.
- Counter wrap (CNT_W=4): accept 17 results -> out_count reads 15 after 15th, 0 after 16th, 1 after 17th.
- Parameter check: WIDTH=1, STAGES=1 and WIDTH=32, STAGES=4 builds -> latency 1 and 4 cycles respectively, results match y_comb at transfer for random a, b, op over 1000 beats with random out_ready.

Source files
------------

// File: rtl/gate_pipe_unit.sv
// gate_pipe_unit: bitwise logic unit with a zero-latency result path and a
// STAGES-deep valid/ready registered copy of the same result, plus an accept counter.
module gate_pipe_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y_comb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_reg,
  output logic [2:0]       y_op,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned OP_W = 3;
  localparam int unsigned LAST = STAGES - 1;

  logic             stg_valid [STAGES];
  logic [WIDTH-1:0] stg_data  [STAGES];
  logic [OP_W-1:0]  stg_op    [STAGES];
  logic             en;

  // Operand logic; shared by the wire path and the stage-0 capture.
  always_comb begin
    y_comb = '0;
    case (op)
      3'd0:    y_comb = a & b;
      3'd1:    y_comb = a | b;
      3'd2:    y_comb = a ^ b;
      3'd3:    y_comb = ~(a & b);
      3'd4:    y_comb = ~(a | b);
      3'd5:    y_comb = ~(a ^ b);
      3'd6:    y_comb = ~a;
      default: y_comb = a & ~b;
    endcase
  end

  // The whole pipe moves as one; bubbles are shifted, never collapsed.
  assign en       = !stg_valid[LAST] || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid[0] <= 1'b0;
      stg_data[0]  <= '0;
      stg_op[0]    <= '0;
    end else if (en) begin
      stg_valid[0] <= in_valid;
      stg_data[0]  <= y_comb;
      stg_op[0]    <= op;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
        stg_op[k]    <= '0;
      end else if (en) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_data[k]  <= stg_data[k-1];
        stg_op[k]    <= stg_op[k-1];
      end
    end
  end

  // Completed-result counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (stg_valid[LAST] && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

  assign out_valid = stg_valid[LAST];
  assign y_reg     = stg_data[LAST];
  assign y_op      = stg_op[LAST];

endmodule

// File: tb/tb_gate_pipe_unit.sv
// Testbench for gate_pipe_unit: four parameterisations checked against a
// slot-queue pipeline model and a per-bit truth-table operator model.
`timescale 1ns/1ps
module tb_gate_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // group 0: WIDTH=8 STAGES=2, shared by dut0 (CNT_W=16) and dut1 (CNT_W=4)
  logic v0, or0;
  logic [7:0] a0, b0;
  logic [2:0] op0;
  logic ir0, ov0, ir1, ov1;
  logic [7:0] yc0, yr0, yc1, yr1;
  logic [2:0] yo0, yo1;
  logic [15:0] cnt0;
  logic [3:0] cnt1;
  // group 2: WIDTH=1 STAGES=1
  logic v2, or2, ir2, ov2;
  logic [0:0] a2, b2, yc2, yr2;
  logic [2:0] op2, yo2;
  logic [15:0] cnt2;
  // group 3: WIDTH=32 STAGES=4
  logic v3, or3, ir3, ov3;
  logic [31:0] a3, b3, yc3, yr3;
  logic [2:0] op3, yo3;
  logic [15:0] cnt3;

  gate_pipe_unit #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .a(a0), .b(b0), .op(op0),
    .y_comb(yc0), .out_valid(ov0), .out_ready(or0), .y_reg(yr0), .y_op(yo0), .out_count(cnt0));
  gate_pipe_unit #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir1), .a(a0), .b(b0), .op(op0),
    .y_comb(yc1), .out_valid(ov1), .out_ready(or0), .y_reg(yr1), .y_op(yo1), .out_count(cnt1));
  gate_pipe_unit #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .a(a2), .b(b2), .op(op2),
    .y_comb(yc2), .out_valid(ov2), .out_ready(or2), .y_reg(yr2), .y_op(yo2), .out_count(cnt2));
  gate_pipe_unit #(.WIDTH(32), .STAGES(4), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .a(a3), .b(b3), .op(op3),
    .y_comb(yc3), .out_valid(ov3), .out_ready(or3), .y_reg(yr3), .y_op(yo3), .out_count(cnt3));

  typedef struct {
    bit          v;
    logic [31:0] r;
    logic [2:0]  o;
  } slot_t;

  slot_t m0[$], m2[$], m3[$];
  int unsigned c0, c2, c3;
  int checks = 0;
  int errors = 0;

  // Per-bit truth table, indexed by {a_bit, b_bit}.
  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] o, input int w);
    logic [3:0]  tt;
    logic [31:0] r;
    r = '0;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b0100;
    endcase
    for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  // Pipeline as a list of slots: on advance, the oldest leaves and a new one enters.
  task automatic adv(inout slot_t q[$], inout int unsigned c, input int st, input bit v,
                     input bit rdy, input logic [31:0] r, input logic [2:0] o);
    slot_t s;
    if (rst) begin
      q = {};
      for (int i = 0; i < st; i++) begin
        s.v = 1'b0; s.r = '0; s.o = '0;
        q.push_back(s);
      end
      c = 0;
    end else begin
      if (q[$].v && rdy) c++;
      if (!q[$].v || rdy) begin
        void'(q.pop_back());
        s.v = v; s.r = r; s.o = o;
        q.push_front(s);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    adv(m0, c0, 2, v0, or0, ref_op(32'(a0), 32'(b0), op0, 8), op0);
    adv(m2, c2, 1, v2, or2, ref_op(32'(a2), 32'(b2), op2, 1), op2);
    adv(m3, c3, 4, v3, or3, ref_op(a3, b3, op3, 32), op3);
  endtask

  task automatic test_reset();
    rst = 1'b0; v0 = 1'b0; or0 = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    checks++; if (yr0 !== 8'h00) begin errors++; $display("FAIL reset_y_reg: got %h want 00", yr0); end
    checks++; if (yo0 !== 3'd0) begin errors++; $display("FAIL reset_y_op: got %0d want 0", yo0); end
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d/%0d want 0", cnt0, cnt1); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
    tick(); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      tick(); @(negedge clk);
    end
    #1;
    checks++; if (cnt0 !== 16'd2 || ov0 !== 1'b1) begin errors++; $display("FAIL pre_reset_stream: got cnt=%0d ov=%b want cnt=2 ov=1", cnt0, ov0); end
    rst = 1'b1;
    tick(); @(negedge clk); #1;
    checks++; if (ov0 !== 1'b0 || yr0 !== 8'h00 || yo0 !== 3'd0 || cnt0 !== 16'd0) begin
      errors++; $display("FAIL mid_reset_state: got ov=%b y=%h op=%0d cnt=%0d want 0/00/0/0", ov0, yr0, yo0, cnt0); end
    tick(); @(negedge clk);
    rst = 1'b0; v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ov0 !== 1'b0 || cnt0 !== 16'd0) begin
        errors++; $display("FAIL post_reset_flush cycle %0d: got ov=%b cnt=%0d want 0/0", i, ov0, cnt0); end
      tick(); @(negedge clk);
    end
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] exp_y [8];
    logic [31:0] r;
    exp_y = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'h42};
    or0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v0 = (i < 8); a0 = 8'hC3; b0 = 8'hA5; op0 = 3'(i % 8);
      #1;
      r = ref_op(32'(a0), 32'(b0), op0, 8);
      if (i < 8) begin
        checks++; if (yc0 !== exp_y[i] || yc0 !== r[7:0]) begin
          errors++; $display("FAIL sweep_y_comb op=%0d: got %h want %h", i, yc0, exp_y[i]); end
      end
      if (i >= 2) begin
        checks++; if (ov0 !== 1'b1 || yr0 !== exp_y[i-2] || yo0 !== 3'(i-2)) begin
          errors++; $display("FAIL sweep_y_reg op=%0d: got ov=%b y=%h op=%0d want 1/%h/%0d", i-2, ov0, yr0, yo0, exp_y[i-2], i-2); end
      end else begin
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sweep_latency: got ov=%b want 0 at cycle %0d", ov0, i); end
      end
      tick(); @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] sb_r[$];
    logic [2:0] sb_o[$];
    logic [7:0] prev_y;
    logic [31:0] r;
    int sent, got, hold, cyc;
    bit stalled, xfer;
    sent = 0; got = 0; hold = 0; cyc = 0; stalled = 0; prev_y = '0;
    v0 = 1'b0; or0 = 1'b1;
    while ((sent < 4 || got < 4) && cyc < 60) begin
      if (!v0 && sent < 4) begin
        v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      end
      if (ov0 && !stalled) begin hold = 3; stalled = 1; prev_y = yr0; end
      or0 = (hold == 0);
      #1;
      if (hold > 0) begin
        checks++; if (ir0 !== 1'b0 || yr0 !== prev_y) begin
          errors++; $display("FAIL bp_hold: got ir=%b y=%h want 0/%h", ir0, yr0, prev_y); end
        hold--;
      end else begin
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", ir0); end
      end
      checks++; if (ov0 !== m0[$].v || (m0[$].v && (yr0 !== m0[$].r[7:0] || yo0 !== m0[$].o))) begin
        errors++; $display("FAIL bp_model: got ov=%b y=%h op=%0d want %b/%h/%0d", ov0, yr0, yo0, m0[$].v, m0[$].r[7:0], m0[$].o); end
      xfer = v0 && ir0;
      if (xfer) begin
        r = ref_op(32'(a0), 32'(b0), op0, 8);
        sb_r.push_back(r[7:0]); sb_o.push_back(op0); sent++;
      end
      if (ov0 && or0) begin
        checks++; if (sb_r.size() == 0 || yr0 !== sb_r[0] || yo0 !== sb_o[0]) begin
          errors++; $display("FAIL bp_order: got y=%h op=%0d at output %0d", yr0, yo0, got); end
        if (sb_r.size() != 0) begin void'(sb_r.pop_front()); void'(sb_o.pop_front()); end
        got++;
      end
      tick(); @(negedge clk);
      if (xfer) v0 = 1'b0;
      cyc++;
    end
    checks++; if (sent != 4 || got != 4 || !stalled) begin
      errors++; $display("FAIL bp_complete: got sent=%0d recv=%0d want 4/4", sent, got); end
  endtask

  task automatic test_bubbles();
    bit pat [4];
    bit exp_v;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    or0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v0 = (i < 4) ? pat[i] : 1'b0;
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      #1;
      if (i >= 2 && i < 6) exp_v = pat[i-2];
      else exp_v = 1'b0;
      checks++; if (ov0 !== exp_v) begin errors++; $display("FAIL bubble cycle %0d: got ov=%b want %b", i, ov0, exp_v); end
      tick(); @(negedge clk);
    end
  endtask

  task automatic test_counter_wrap();
    int n, cyc;
    rst = 1'b1; v0 = 1'b0; or0 = 1'b1;
    tick(); @(negedge clk);
    rst = 1'b0; n = 0; cyc = 0;
    while (n < 17 && cyc < 40) begin
      v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      #1;
      checks++; if (cnt1 !== 4'(n % 16) || cnt0 !== 16'(n) || ov1 !== m0[$].v) begin
        errors++; $display("FAIL count_wrap after %0d: got %0d/%0d want %0d/%0d", n, cnt1, cnt0, n % 16, n); end
      if (ov0 && or0) n++;
      tick(); @(negedge clk);
      cyc++;
    end
    v0 = 1'b0;
    #1;
    checks++; if (n != 17 || cnt1 !== 4'd1 || cnt0 !== 16'd17) begin
      errors++; $display("FAIL count_wrap_final: got %0d/%0d after %0d want 1/17", cnt1, cnt0, n); end
  endtask

  task automatic test_latency_params();
    int l2, l3;
    l2 = 0; l3 = 0;
    rst = 1'b1; v2 = 1'b0; v3 = 1'b0; or2 = 1'b1; or3 = 1'b1;
    tick(); @(negedge clk);
    rst = 1'b0;
    v2 = 1'b1; a2 = 1'($urandom); b2 = 1'($urandom); op2 = 3'($urandom);
    v3 = 1'b1; a3 = $urandom; b3 = $urandom; op3 = 3'($urandom);
    tick(); @(negedge clk);
    v2 = 1'b0; v3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (l2 == 0 && ov2 === 1'b1) l2 = k;
      if (l3 == 0 && ov3 === 1'b1) l3 = k;
      tick(); @(negedge clk);
    end
    checks++; if (l2 != 1) begin errors++; $display("FAIL latency_s1: got %0d want 1", l2); end
    checks++; if (l3 != 4) begin errors++; $display("FAIL latency_s4: got %0d want 4", l3); end
  endtask

  task automatic test_random_params();
    int sent2, sent3, cyc;
    bit x2, x3;
    logic [31:0] r;
    sent2 = 0; sent3 = 0; cyc = 0;
    v2 = 1'b0; v3 = 1'b0; v0 = 1'b0;
    while ((sent2 < 1000 || sent3 < 1000) && cyc < 5000) begin
      if (!v2) begin v2 = ($urandom_range(0, 3) != 0); a2 = 1'($urandom); b2 = 1'($urandom); op2 = 3'($urandom); end
      if (!v3) begin v3 = ($urandom_range(0, 3) != 0); a3 = $urandom; b3 = $urandom; op3 = 3'($urandom); end
      or2 = ($urandom_range(0, 3) != 0);
      or3 = ($urandom_range(0, 2) != 0);
      #1;
      r = ref_op(32'(a2), 32'(b2), op2, 1);
      checks++; if (yc2 !== r[0:0] || ir2 !== (!m2[$].v || or2) || ov2 !== m2[$].v) begin
        errors++; $display("FAIL rand_w1_ctrl: got yc=%b ir=%b ov=%b want %b/%b/%b", yc2, ir2, ov2, r[0], !m2[$].v || or2, m2[$].v); end
      checks++; if ((m2[$].v && (yr2 !== m2[$].r[0:0] || yo2 !== m2[$].o)) || cnt2 !== 16'(c2)) begin
        errors++; $display("FAIL rand_w1_data: got y=%b op=%0d cnt=%0d want %b/%0d/%0d", yr2, yo2, cnt2, m2[$].r[0], m2[$].o, c2); end
      r = ref_op(a3, b3, op3, 32);
      checks++; if (yc3 !== r || ir3 !== (!m3[$].v || or3) || ov3 !== m3[$].v) begin
        errors++; $display("FAIL rand_w32_ctrl: got yc=%h ir=%b ov=%b want %h/%b/%b", yc3, ir3, ov3, r, !m3[$].v || or3, m3[$].v); end
      checks++; if ((m3[$].v && (yr3 !== m3[$].r || yo3 !== m3[$].o)) || cnt3 !== 16'(c3)) begin
        errors++; $display("FAIL rand_w32_data: got y=%h op=%0d cnt=%0d want %h/%0d/%0d", yr3, yo3, cnt3, m3[$].r, m3[$].o, c3); end
      x2 = v2 && ir2;
      x3 = v3 && ir3;
      if (x2) sent2++;
      if (x3) sent3++;
      tick(); @(negedge clk);
      if (x2) v2 = 1'b0;
      if (x3) v3 = 1'b0;
      cyc++;
    end
    checks++; if (sent2 < 1000 || sent3 < 1000) begin
      errors++; $display("FAIL rand_budget: got %0d/%0d beats want 1000 each", sent2, sent3); end
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; or0 = 1'b1; a0 = '0; b0 = '0; op0 = '0;
    v2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; op2 = '0;
    v3 = 1'b0; or3 = 1'b1; a3 = '0; b3 = '0; op3 = '0;
    tick(); tick(); @(negedge clk);
    test_reset();
    test_opcode_sweep();
    test_backpressure();
    test_bubbles();
    test_counter_wrap();
    test_latency_params();
    test_random_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
